binary_search_controller: RTL and testbench
===========================================

BINARY_SEARCH_CONTROLLER -- requirements
Module: binary_search_controller

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Start, input, 1 bit: request a new search; sampled on the rising edge of Clk.
REQ-004 SHALL have ports G, E, L, input, 1 bit each, driven by the comparator stage:
- G: reference > probe.
- E: reference == probe.
- L: reference < probe.
REQ-005 SHALL have port ComparisonInput, output, 4 bits: registered probe value driven to the comparator.
REQ-006 SHALL have port Busy, output, 1 bit: high while in the COMPARE state.
REQ-007 SHALL have port Done, output, 1 bit: high while in the DONE state.
REQ-008 SHALL have port Error, output, 1 bit: high while in the ERROR state.
REQ-009 SHALL have port Result, output, 4 bits: matched reference value, valid while Done=1.
REQ-010 SHALL have port Steps, output, 3 bits: number of probes evaluated in the current or last search.

Function
REQ-011 SHALL implement the states IDLE, COMPARE, DONE and ERROR.
REQ-012 SHALL hold registers Low and High (4 bits each); probe = (Low+High)>>1, with the sum computed 5 bits wide.
REQ-013 In IDLE, DONE or ERROR, Start=1 SHALL:
- set Low=0, High=15, Steps=0 and ComparisonInput=7;
- enter COMPARE on the same edge.
REQ-014 In COMPARE, each edge SHALL sample G/E/L against the current ComparisonInput and increment Steps.
REQ-015 On E=1: SHALL set Result=ComparisonInput and enter DONE.
REQ-016 On G=1 with ComparisonInput<15: SHALL set Low=ComparisonInput+1 and drive the next probe from the new Low/High on the following cycle.
REQ-017 On L=1 with ComparisonInput>0: SHALL set High=ComparisonInput-1 and drive the next probe likewise.
REQ-018 The following SHALL enter ERROR without updating Low/High, in place of REQ-016/REQ-017:
- G=1 with ComparisonInput=15;
- L=1 with ComparisonInput=0;
- any update that would make Low>High.
REQ-019 The worst-case search SHALL be 5 probes. Done SHALL assert N+1 cycles after the Start edge, where N is the probe count.
REQ-020 Start SHALL be ignored while in COMPARE.
REQ-021 DONE and ERROR SHALL hold until Start or reset. Result, Steps and ComparisonInput SHALL be held stable in these states.
REQ-022 Busy, Done and Error SHALL be mutually exclusive and registered (no combinational path from G/E/L to any output).

Reset
REQ-023 Reset_n=0 SHALL immediately force the following, regardless of Clk:
- state IDLE;
- ComparisonInput=0, Result=0, Steps=0;
- Low=0, High=15;
- Busy=0, Done=0, Error=0.
REQ-024 Reset asserted mid-search SHALL abort the search. No Done or Error SHALL be produced for it, and operation SHALL resume from IDLE on the first edge after Reset_n returns high.

Configuration
REQ-025 SHALL support macro BINARY_SEARCH_ONEHOT_CHECK_EN.
- Defined: in COMPARE, any G/E/L pattern with other than exactly one bit high SHALL enter ERROR.
- Undefined: priority E > G > L SHALL apply, and a pattern with none of G/E/L high SHALL leave Low/High unchanged and re-probe, still incrementing Steps.
REQ-026 Both configurations SHALL be identical for legal one-hot comparator inputs.

Verification
REQ-027 Reference=7, Start pulse:
- 1 probe (7);
- Done=1 two cycles after the Start edge;
- Result=7, Steps=1.
REQ-028 Reference=15:
- probes 7, 11, 13, 14, 15;
- Done six cycles after Start;
- Result=15, Steps=5.
REQ-029 Reference=0:
- probes 7, 3, 1, 0;
- Result=0, Steps=4;
- a second Start from DONE with Reference=9 gives probes 7, 11, 9 and Result=9.
REQ-030 With the macro defined, forcing G=E=1 on the first probe SHALL give Error=1 next cycle with Steps=1.
REQ-031 Forcing G=1 whenever the probe is 15 SHALL give Error=1 with Steps=5.
REQ-032 Mid-search handling, Reference=15:
- Start re-asserted after the first probe is ignored, and the search completes normally;
- Reset_n pulsed low during the second search clears all outputs to 0 immediately, with no Done.

Source files
------------

// File: rtl/binary_search_controller.sv
// Binary search controller: walks a 4-bit probe toward the reference value
// using greater/equal/less flags from an external comparator stage.
// One probe is evaluated per clock while searching.
// Optional build macro BINARY_SEARCH_ONEHOT_CHECK_EN: when defined, a
// comparator pattern other than exactly one of G/E/L high aborts the search
// with Error; when undefined, E beats G beats L, and an all-low pattern
// re-probes the same value.

module binary_search_controller (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       G,
  input  logic       E,
  input  logic       L,
  output logic [3:0] ComparisonInput,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [3:0] Result,
  output logic [2:0] Steps
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } SearchState;

  localparam logic [3:0] LowInit    = 4'd0;
  localparam logic [3:0] HighInit   = 4'd15;
  localparam logic [3:0] FirstProbe = 4'd7;

  SearchState state;
  SearchState stateNext;

  logic [3:0] lowReg;
  logic [3:0] highReg;
  logic [3:0] lowNext;
  logic [3:0] highNext;
  logic [3:0] probeNext;
  logic [3:0] resultNext;
  logic [2:0] stepsNext;

  logic       patternBad;
  logic       eHit;
  logic       gHit;
  logic       lHit;

  logic [4:0] raisedLow;
  logic [3:0] loweredHigh;

  // Midpoint of the window; the sum is kept 5 bits wide so 15+15 cannot wrap.
  function automatic logic [3:0] midpoint(input logic [3:0] lo, input logic [3:0] hi);
    return 4'(({1'b0, lo} + {1'b0, hi}) >> 1);
  endfunction

  // Candidate window edges if the current probe is moved past. raisedLow is
  // one bit wider so that probe 15 shows up as 16 and never wraps to 0.
  assign raisedLow   = {1'b0, ComparisonInput} + 5'd1;
  assign loweredHigh = ComparisonInput - 4'd1;

  // Reduce the comparator flags to one decision for this probe.
  always_comb begin
    patternBad = 1'b0;
    eHit       = 1'b0;
    gHit       = 1'b0;
    lHit       = 1'b0;
`ifdef BINARY_SEARCH_ONEHOT_CHECK_EN
    patternBad = !({G, E, L} inside {3'b100, 3'b010, 3'b001});
    eHit       = E && !patternBad;
    gHit       = G && !patternBad;
    lHit       = L && !patternBad;
`else
    eHit       = E;
    gHit       = G && !E;
    lHit       = L && !E && !G;
`endif
  end

  // Next-state and datapath decisions; every register holds unless changed.
  always_comb begin
    stateNext  = state;
    lowNext    = lowReg;
    highNext   = highReg;
    probeNext  = ComparisonInput;
    resultNext = Result;
    stepsNext  = Steps;

    case (state)
      COMPARE: begin
        stepsNext = Steps + 3'd1;
        if (patternBad) begin
          stateNext = ERROR;
        end else if (eHit) begin
          resultNext = ComparisonInput;
          stateNext  = DONE;
        end else if (gHit) begin
          if ((ComparisonInput == 4'd15) || (raisedLow > {1'b0, highReg})) begin
            stateNext = ERROR;
          end else begin
            lowNext   = raisedLow[3:0];
            probeNext = midpoint(raisedLow[3:0], highReg);
          end
        end else if (lHit) begin
          if ((ComparisonInput == 4'd0) || (lowReg > loweredHigh)) begin
            stateNext = ERROR;
          end else begin
            highNext  = loweredHigh;
            probeNext = midpoint(lowReg, loweredHigh);
          end
        end
        // No flag at all: window untouched, the same probe is tried again.
      end

      default: begin
        // IDLE, DONE and ERROR all accept a fresh request.
        if (Start) begin
          stateNext = COMPARE;
          lowNext   = LowInit;
          highNext  = HighInit;
          stepsNext = 3'd0;
          probeNext = FirstProbe;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Search window, probe, result and probe counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lowReg          <= LowInit;
      highReg         <= HighInit;
      ComparisonInput <= 4'd0;
      Result          <= 4'd0;
      Steps           <= 3'd0;
    end else begin
      lowReg          <= lowNext;
      highReg         <= highNext;
      ComparisonInput <= probeNext;
      Result          <= resultNext;
      Steps           <= stepsNext;
    end
  end

  // Status flags come straight from flops so G/E/L never reach an output combinationally.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Error <= 1'b0;
    end else begin
      Busy  <= (stateNext == COMPARE);
      Done  <= (stateNext == DONE);
      Error <= (stateNext == ERROR);
    end
  end

endmodule

// File: tb/tb_binary_search_controller.sv
// Testbench for binary_search_controller. Plays the comparator stage against
// a chosen reference value, keeps a search-level model of the expected
// outputs, and checks the DUT against it on every falling clock edge.

module tb_binary_search_controller;

  logic       SimClk;
  logic       Reset_n;
  logic       Start;
  logic       G;
  logic       E;
  logic       L;
  logic [3:0] ComparisonInput;
  logic       Busy;
  logic       Done;
  logic       Error;
  logic [3:0] Result;
  logic [2:0] Steps;

  int passCount  = 0;
  int checkCount = 0;

  // Comparator behaviour: 0 honest, 1 claims "greater" at probe 15,
  // 2 also raises G at probe 7.
  int refVal  = 0;
  int cmpMode = 0;

  // Model: 0 idle after reset, 1 searching, 2 done, 3 error.
  int mPhase   = 0;
  int mOutcome = 0;
  int mIdx     = 0;
  int mCi      = 0;
  int mSteps   = 0;
  int mResult  = 0;
  int mProbes[$];

  int seenWord  = 0;
  int seenCount = 0;
  bit checkEn   = 0;

  binary_search_controller dut (
    .Clk             (SimClk),
    .Reset_n         (Reset_n),
    .Start           (Start),
    .G               (G),
    .E               (E),
    .L               (L),
    .ComparisonInput (ComparisonInput),
    .Busy            (Busy),
    .Done            (Done),
    .Error           (Error),
    .Result          (Result),
    .Steps           (Steps)
  );

  initial SimClk = 1'b0;
  always #5 SimClk = ~SimClk;

  // Comparator response {G,E,L} for a reference and a probe.
  function automatic logic [2:0] respond(input int refV, input int mode, input int p);
    logic [2:0] r;
    r = {refV > p, refV == p, refV < p};
    if (mode == 1 && p == 15) r = 3'b100;
    if (mode == 2 && p == 7)  r[2] = 1'b1;
    return r;
  endfunction

  assign {G, E, L} = respond(refVal, cmpMode, int'(ComparisonInput));

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
  endtask

  // Plain binary search over 0..15: list the probes and how the search ends.
  task automatic planSearch(input int refV, input int mode);
    int lo, hi, p;
    logic [2:0] r;
    bit fin, bad;
    lo = 0; hi = 15; fin = 0;
    mProbes.delete();
    while (!fin && mProbes.size() < 8) begin
      p = (lo + hi) / 2;
      mProbes.push_back(p);
      r = respond(refV, mode, p);
      bad = 0;
`ifdef BINARY_SEARCH_ONEHOT_CHECK_EN
      bad = ($countones(r) != 1);
`endif
      if (bad) begin
        mOutcome = 3; fin = 1;
      end else if (r[1]) begin
        mOutcome = 2; fin = 1;
      end else if (r[2]) begin
        if (p == 15 || p + 1 > hi) begin mOutcome = 3; fin = 1; end
        else lo = p + 1;
      end else if (r[0]) begin
        if (p == 0 || lo > p - 1) begin mOutcome = 3; fin = 1; end
        else hi = p - 1;
      end
    end
  endtask

  // Advance the model one clock, or clear it on reset.
  initial begin
    forever begin
      @(posedge SimClk or negedge Reset_n);
      if (!Reset_n) begin
        mPhase = 0; mCi = 0; mSteps = 0; mResult = 0;
      end else if (mPhase == 1) begin
        mIdx++;
        mSteps = mIdx;
        if (mIdx == mProbes.size()) begin
          mPhase = mOutcome;
          if (mOutcome == 2) mResult = mProbes[mIdx - 1];
        end else begin
          mCi = mProbes[mIdx];
        end
      end else if (Start) begin
        planSearch(refVal, cmpMode);
        mIdx = 0; mSteps = 0; mCi = mProbes[0]; mPhase = 1;
      end
    end
  end

  // Compare the DUT against the model every cycle.
  initial begin
    forever begin
      @(negedge SimClk);
      if (checkEn) begin
        checkOutput("busy",  int'(Busy),  int'(mPhase == 1));
        checkOutput("done",  int'(Done),  int'(mPhase == 2));
        checkOutput("error", int'(Error), int'(mPhase == 3));
        checkOutput("probe", int'(ComparisonInput), mCi);
        checkOutput("steps", int'(Steps), mSteps);
        if (mPhase == 0 || mPhase == 2) checkOutput("result", int'(Result), mResult);
        if (Busy) begin
          seenWord = (seenWord << 4) | int'(ComparisonInput);
          seenCount++;
        end
      end
    end
  end

  // Pulse Start and count cycles (from the one Start is driven in) until Done or Error.
  task automatic applyStimulus(input int refV, input int mode, output int latency);
    @(posedge SimClk); #1;
    refVal = refV; cmpMode = mode;
    seenWord = 0; seenCount = 0;
    Start = 1'b1;
    @(posedge SimClk); #1;
    Start = 1'b0;
    latency = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge SimClk);
      if (Done || Error) begin
        latency = k;
        break;
      end
    end
    if (latency == 0) checkOutput("search timeout", 0, 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"},   int'(Busy), 0);
    checkOutput({tag, " done"},   int'(Done), 0);
    checkOutput({tag, " error"},  int'(Error), 0);
    checkOutput({tag, " probe"},  int'(ComparisonInput), 0);
    checkOutput({tag, " result"}, int'(Result), 0);
    checkOutput({tag, " steps"},  int'(Steps), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int flagsSeen;
    Start = 1'b0;
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #2 checkAllZero("reset");
    checkEn = 1;
    #19 Reset_n = 1'b1;

    // Reference 7: a single probe.
    applyStimulus(7, 0, lat);
    checkOutput("ref7 latency", lat, 2);
    checkOutput("ref7 result", int'(Result), 7);
    checkOutput("ref7 steps", int'(Steps), 1);
    checkOutput("ref7 probes", seenWord, 'h7);

    // Reference 15: worst case, five probes.
    applyStimulus(15, 0, lat);
    checkOutput("ref15 latency", lat, 6);
    checkOutput("ref15 result", int'(Result), 15);
    checkOutput("ref15 steps", int'(Steps), 5);
    checkOutput("ref15 probes", seenWord, 'h7BDEF);

    // Reference 0, then a new search straight from DONE for 9.
    applyStimulus(0, 0, lat);
    checkOutput("ref0 latency", lat, 5);
    checkOutput("ref0 result", int'(Result), 0);
    checkOutput("ref0 steps", int'(Steps), 4);
    checkOutput("ref0 probes", seenWord, 'h7310);
    checkOutput("ref0 probe count", seenCount, 4);
    applyStimulus(9, 0, lat);
    checkOutput("ref9 result", int'(Result), 9);
    checkOutput("ref9 steps", int'(Steps), 3);
    checkOutput("ref9 probes", seenWord, 'h7B9);

    // G and E together on the first probe.
    applyStimulus(7, 2, lat);
    checkOutput("ge latency", lat, 2);
    checkOutput("ge steps", int'(Steps), 1);
`ifdef BINARY_SEARCH_ONEHOT_CHECK_EN
    checkOutput("ge error", int'(Error), 1);
`else
    checkOutput("ge done", int'(Done), 1);
    checkOutput("ge result", int'(Result), 7);
`endif

    // Comparator insists the reference is above 15.
    applyStimulus(15, 1, lat);
    checkOutput("g15 error", int'(Error), 1);
    checkOutput("g15 done", int'(Done), 0);
    checkOutput("g15 steps", int'(Steps), 5);
    checkOutput("g15 latency", lat, 6);

    // Start re-asserted mid-search is ignored (search starts from ERROR).
    @(posedge SimClk); #1;
    refVal = 15; cmpMode = 0; seenWord = 0; seenCount = 0;
    Start = 1'b1;
    @(posedge SimClk); #1 Start = 1'b0;
    @(posedge SimClk); #1 Start = 1'b1;
    @(posedge SimClk); #1 Start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge SimClk);
      if (Done || Error) begin lat = k; break; end
    end
    checkOutput("restart ignored finished", int'(lat != 0), 1);
    checkOutput("restart ignored result", int'(Result), 15);
    checkOutput("restart ignored steps", int'(Steps), 5);
    checkOutput("restart ignored probes", seenWord, 'h7BDEF);

    // Reset pulsed during a second search aborts it.
    @(posedge SimClk); #1;
    refVal = 15; Start = 1'b1;
    @(posedge SimClk); #1 Start = 1'b0;
    @(posedge SimClk); #3 Reset_n = 1'b0;
    #1 checkAllZero("abort");
    @(negedge SimClk);
    @(negedge SimClk); #2 Reset_n = 1'b1;
    flagsSeen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge SimClk);
      if (Done || Error) flagsSeen++;
    end
    checkOutput("abort no done", flagsSeen, 0);

    // Operation resumes from IDLE after the abort.
    applyStimulus(5, 0, lat);
    checkOutput("ref5 latency", lat, 4);
    checkOutput("ref5 result", int'(Result), 5);
    checkOutput("ref5 probes", seenWord, 'h735);

    repeat (2) @(negedge SimClk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
